// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory refill engine and its line buffer.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int unsigned BEATS           = 4;
  localparam int unsigned OFFSET_W        = 2;
  localparam int unsigned LINE_W          = 128;
  localparam int unsigned TIMEOUT_DEFAULT = 8;

  // The memory reports the final beat of a burst on this offset.
  function automatic logic is_last_beat(input logic [OFFSET_W-1:0] offset);
    return offset == OFFSET_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Four-word line register file: offset-indexed writes, cleared by reset, flat read port.
module refill_line_buf
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    we,
  input  logic [OFFSET_W-1:0]     offset,
  input  logic [DATA_W-1:0]       wdata,
  output logic [BEATS*DATA_W-1:0] line
);

  logic [DATA_W-1:0] words [BEATS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BEATS; i++) begin
        words[i] <= '0;
      end
    end else if (we) begin
      words[offset] <= wdata;
    end
  end

  // Word k lands at bits [DATA_W*k +: DATA_W].
  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) begin
      line[i*DATA_W +: DATA_W] = words[i];
    end
  end

endmodule

// File: rtl/mem_refill_ctrl.sv
// Burst-port initiator for the cache FSM: 4-beat line refills and single-word
// write-throughs, with a mandatory idle gap and sticky protocol/timeout error.
module mem_refill_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    dm_re,
  output logic                    dm_we,
  output logic [ADDR_W-1:0]       dm_addrs,
  output logic [DATA_W-1:0]       dm_wd,
  input  logic [DATA_W-1:0]       dm_rd_2cache,
  input  logic [OFFSET_W-1:0]     word_offset,
  input  logic                    ready,
  output logic [BEATS*DATA_W-1:0] line_data,
  output logic                    done,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                req_ready_nxt;
  logic                dm_re_nxt, dm_we_nxt;
  logic [ADDR_W-1:0]   dm_addrs_nxt;
  logic [DATA_W-1:0]   dm_wd_nxt;
  logic                done_nxt, busy_nxt, err_nxt;
  logic                beat_we_c;
  logic                timeout_c;

  // Every edge spent in READ deposits the presented word at the memory's offset.
  assign beat_we_c = (state == READ);
  assign timeout_c = (timer == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    req_ready_nxt = req_ready;
    dm_re_nxt     = dm_re;
    dm_we_nxt     = dm_we;
    dm_addrs_nxt  = dm_addrs;
    dm_wd_nxt     = dm_wd;
    done_nxt      = 1'b0;
    busy_nxt      = busy;
    err_nxt       = err;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_nxt = 1'b0;
          busy_nxt      = 1'b1;
          timer_nxt     = '0;
          dm_addrs_nxt  = req_addr;
          if (req_we) begin
            dm_we_nxt = 1'b1;
            dm_wd_nxt = req_wdata;
            state_nxt = WRITE;
          end else begin
            dm_re_nxt = 1'b1;
            state_nxt = READ;
          end
        end
      end

      READ, WRITE: begin
        timer_nxt = timer + TIMER_W'(1);
        if (ready) begin
          // Early completion is flagged but still honoured as the end of burst.
          if (!is_last_beat(word_offset)) begin
            err_nxt = 1'b1;
          end
          dm_re_nxt = 1'b0;
          dm_we_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = GAP;
        end else if (timeout_c) begin
          err_nxt   = 1'b1;
          dm_re_nxt = 1'b0;
          dm_we_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = GAP;
        end
      end

      GAP: begin
        // One dead cycle lets the memory's beat counter fall back to zero.
        busy_nxt      = 1'b0;
        req_ready_nxt = 1'b1;
        state_nxt     = IDLE;
      end

      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
        dm_re_nxt     = 1'b0;
        dm_we_nxt     = 1'b0;
        busy_nxt      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      req_ready <= 1'b1;
      dm_re     <= 1'b0;
      dm_we     <= 1'b0;
      dm_addrs  <= '0;
      dm_wd     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      req_ready <= req_ready_nxt;
      dm_re     <= dm_re_nxt;
      dm_we     <= dm_we_nxt;
      dm_addrs  <= dm_addrs_nxt;
      dm_wd     <= dm_wd_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      err       <= err_nxt;
    end
  end

  refill_line_buf #(
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (beat_we_c),
    .offset  (word_offset),
    .wdata   (dm_rd_2cache),
    .line    (line_data)
  );

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl with a burst-memory responder and a
// scoreboard of expected completions.
module tb_mem_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_we = 1'b0;
  logic [9:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         dm_re, dm_we;
  logic [9:0]   dm_addrs;
  logic [31:0]  dm_wd;
  logic [31:0]  dm_rd_2cache;
  logic [1:0]   word_offset;
  logic         ready;
  logic [127:0] line_data;
  logic         done, busy, err;

  always #5 clk = ~clk;

  mem_refill_ctrl #(
    .ADDR_W  (10),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .dm_re        (dm_re),
    .dm_we        (dm_we),
    .dm_addrs     (dm_addrs),
    .dm_wd        (dm_wd),
    .dm_rd_2cache (dm_rd_2cache),
    .word_offset  (word_offset),
    .ready        (ready),
    .line_data    (line_data),
    .done         (done),
    .busy         (busy),
    .err          (err)
  );

  // Memory responder: mode 0 = ready on beat 3, 1 = never ready, 2 = ready on beat 1.
  logic [31:0] mem [1024];
  bit          loaded = 1'b0;
  logic [3:0]  cnt;
  int          mode = 0;

  assign word_offset  = cnt[1:0];
  assign dm_rd_2cache = mem[{dm_addrs[9:2], word_offset}];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(i) + 32'h0C0;
      loaded <= 1'b1;
    end else if (dm_we && ready) begin
      mem[dm_addrs] <= dm_wd;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (dm_re || dm_we) cnt <= cnt + 4'd1;
    else cnt <= '0;
  end

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) ready <= 1'b0;
    else if (mode == 1) ready <= 1'b0;
    else if (mode == 2) ready <= (dm_re || dm_we) && (cnt == 4'd1);
    else ready <= (dm_re || dm_we) && (cnt == 4'd3);
  end

  typedef struct {
    bit           we;
    logic [127:0] line;
    bit           err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           n_assert = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] line_model = '0;
  bit           err_model = 1'b0;
  logic [31:0]  wr_model [int];
  bit           prev_done = 1'b0;
  bit           prev_act = 1'b0;

  function automatic logic [31:0] mem_model(input int a);
    if (wr_model.exists(a)) return wr_model[a];
    return 32'(a) + 32'h0C0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and retire any completion.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("re_we_exclusive", 128'(dm_re & dm_we), 128'(0));
    check("ready_only_idle", 128'(req_ready), 128'(!busy));
    if ((dm_re || dm_we) && !prev_act) check("first_offset", 128'(word_offset), 128'(0));
    if (prev_done) begin
      check("done_one_cycle", 128'(done), 128'(0));
      check("busy_after_gap", 128'(busy), 128'(0));
    end
    if (done) begin
      check("gap_enables_low", 128'({dm_re, dm_we}), 128'(0));
      check("sb_pending", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("latency", 128'(cyc - e.acc), 128'(e.lat));
        check("err", 128'(err), 128'(e.err));
        if (!e.we) check("line_data", line_data, e.line);
      end
    end
    prev_done = done;
    prev_act  = dm_re || dm_we;
  endtask

  task automatic issue(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                       input bit keep, input int lat, input int nwords, output int acc);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    check("req_ready_wait", 128'(req_ready), 128'(1));
    acc   = cyc;
    e.we  = we;
    e.acc = cyc;
    e.lat = lat;
    if (mode != 0) err_model = 1'b1;
    e.err = err_model;
    if (we) begin
      if (mode == 0) wr_model[int'(addr)] = wd;
    end else begin
      for (int k = 0; k < nwords; k++)
        line_model[32*k +: 32] = mem_model(int'({addr[9:2], 2'(k)}));
    end
    e.line = line_model;
    sb.push_back(e);
    step();
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0, acc1, acc2, acc3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dm_re", 128'(dm_re), 128'(0));
    check("rst_dm_we", 128'(dm_we), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_dm_addrs", 128'(dm_addrs), 128'(0));
    check("rst_dm_wd", 128'(dm_wd), 128'(0));
    check("rst_line", line_data, 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_req_ready", 128'(req_ready), 128'(1));

    // Refill of line 0x040 via word 0x041
    issue(1'b0, 10'h041, 32'h0, 1'b0, 5, 4, acc0);
    for (int k = 0; k < 4; k++) begin
      check("t1_dm_re", 128'(dm_re), 128'(1));
      check("t1_dm_addrs", 128'(dm_addrs), 128'(10'h041));
      if (k < 3) step();
    end
    step();
    check("t1_line", line_data, 128'h00000103_00000102_00000101_00000100);
    check("t1_err", 128'(err), 128'(0));
    check("t1_done", 128'(done), 128'(1));
    step();
    check("t1_idle", 128'(req_ready), 128'(1));

    // Write-through then refill of the same line
    issue(1'b1, 10'h2A0, 32'hDEADBEEF, 1'b0, 5, 0, acc0);
    for (int k = 0; k < 4; k++) begin
      check("t2_dm_we", 128'(dm_we), 128'(1));
      check("t2_dm_re", 128'(dm_re), 128'(0));
      check("t2_dm_wd", 128'(dm_wd), 128'(32'hDEADBEEF));
      check("t2_dm_addrs", 128'(dm_addrs), 128'(10'h2A0));
      if (k < 3) step();
    end
    step();
    check("t2_wr_done", 128'(done), 128'(1));
    step();
    issue(1'b0, 10'h2A0, 32'h0, 1'b0, 5, 4, acc0);
    repeat (4) step();
    check("t2_word0", 128'(line_data[31:0]), 128'(32'hDEADBEEF));
    step();

    // req_valid held high, alternating read/write
    issue(1'b0, 10'h044, 32'h0, 1'b1, 5, 4, acc0);
    issue(1'b1, 10'h045, 32'hCAFE0001, 1'b1, 5, 0, acc1);
    check("t3_spacing_1", 128'(acc1 - acc0), 128'(6));
    issue(1'b0, 10'h046, 32'h0, 1'b1, 5, 4, acc2);
    check("t3_spacing_2", 128'(acc2 - acc1), 128'(6));
    issue(1'b1, 10'h3FF, 32'h12345678, 1'b0, 5, 0, acc3);
    check("t3_spacing_3", 128'(acc3 - acc2), 128'(6));
    repeat (6) step();
    check("t3_drained", 128'(sb.size()), 128'(0));

    // Responder never ready: timeout, then a normal refill with err still set
    mode = 1;
    issue(1'b0, 10'h080, 32'h0, 1'b0, 9, 4, acc0);
    repeat (7) step();
    check("t4_re_held", 128'(dm_re), 128'(1));
    check("t4_err_pre", 128'(err), 128'(0));
    step();
    check("t4_err", 128'(err), 128'(1));
    step();
    check("t4_busy_clear", 128'(busy), 128'(0));
    mode = 0;
    issue(1'b0, 10'h081, 32'h0, 1'b0, 5, 4, acc0);
    repeat (5) step();
    check("t4_err_sticky", 128'(err), 128'(1));

    // Reset pulse during beat 2 of a refill
    issue(1'b0, 10'h0C0, 32'h0, 1'b0, 5, 4, acc0);
    step();
    step();
    check("t5_beat2", 128'(word_offset), 128'(2));
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_rst_dm_re", 128'(dm_re), 128'(0));
    check("t5_rst_line", line_data, 128'(0));
    check("t5_rst_err", 128'(err), 128'(0));
    check("t5_rst_busy", 128'(busy), 128'(0));
    sb.delete();
    err_model  = 1'b0;
    line_model = '0;
    prev_done  = 1'b0;
    prev_act   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("t5_req_ready", 128'(req_ready), 128'(1));
    issue(1'b0, 10'h0C0, 32'h0, 1'b0, 5, 4, acc0);
    repeat (5) step();

    // Ready on beat 1: protocol error, early completion, back to idle
    mode = 2;
    issue(1'b0, 10'h100, 32'h0, 1'b0, 3, 2, acc0);
    step();
    step();
    check("t6_err", 128'(err), 128'(1));
    mode = 0;
    step();
    check("t6_idle", 128'(req_ready), 128'(1));
    check("t6_line", line_data, 128'h00000183_00000182_000001C1_000001C0);
    check("t6_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
